// File: rtl/pipelined_adder_pkg.sv
// ============================================================================
// Module      : pipelined_adder_pkg
// Description : Shared types and elaboration helpers for the pipelined adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipelined_adder_pkg;

    // Per-stage control record. The partial-sum and remaining-operand fields
    // change width from stage to stage, so each stage declares them alongside.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage : pipelined_adder_pkg

`default_nettype wire

// File: rtl/pipelined_adder_if.sv
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result valid-ready bus of the pipelined adder.
//               Carries ovf only when PIPELINED_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface : pipelined_adder_if

`default_nettype wire

// File: rtl/pipelined_adder_chunk.sv
// ============================================================================
// Module      : pipelined_adder_chunk
// Description : Combinational CHUNK-bit ripple-carry adder built from a chain
//               of full adders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_co = w_c[CHUNK];

endmodule : pipelined_adder_chunk

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit ripple adder split into STAGES registered chunks with
//               valid/ready handshake. Optional macro: PIPELINED_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    localparam int c_CHUNK = chunk_width(WIDTH, STAGES);

    // Single advance enable: the whole pipe moves or the whole pipe holds.
    logic w_adv;

    assign w_adv        = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_SRC  = WIDTH - k * c_CHUNK;
        localparam int c_DONE = (k + 1) * c_CHUNK;
        localparam int c_REM  = WIDTH - c_DONE;

        logic [c_SRC-1:0]   w_src_a;
        logic [c_SRC-1:0]   w_src_b;
        logic               w_ci;
        logic               w_vin;
        logic [c_DONE-1:0]  w_sum_nxt;
        logic [c_CHUNK-1:0] w_s;
        logic               w_co;

        stage_ctl_t         r_ctl;
        logic [c_DONE-1:0]  r_sum;

        if (k == 0) begin : g_head
            assign w_src_a   = bus.a;
            assign w_src_b   = bus.b;
            assign w_ci      = bus.cin;
            assign w_vin     = bus.in_valid;
            assign w_sum_nxt = w_s;
        end else begin : g_body
            assign w_src_a   = g_stage[k-1].g_rem.r_a;
            assign w_src_b   = g_stage[k-1].g_rem.r_b;
            assign w_ci      = g_stage[k-1].r_ctl.carry;
            assign w_vin     = g_stage[k-1].r_ctl.valid;
            assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
        end

        pipelined_adder_chunk #(
            .CHUNK (c_CHUNK)
        ) u_chunk (
            .i_a  (w_src_a[c_CHUNK-1:0]),
            .i_b  (w_src_b[c_CHUNK-1:0]),
            .i_ci (w_ci),
            .o_s  (w_s),
            .o_co (w_co)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctl <= '0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_ctl.valid <= w_vin;
                r_ctl.carry <= w_co;
                r_sum       <= w_sum_nxt;
            end
        end

        // Operand bits above this chunk ride along until their stage.
        if (c_REM > 0) begin : g_rem
            logic [c_REM-1:0] r_a;
            logic [c_REM-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_src_a[c_SRC-1:c_CHUNK];
                    r_b <= w_src_b[c_SRC-1:c_CHUNK];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic w_c_msb;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB sum bit.
            assign w_c_msb = w_src_a[c_CHUNK-1] ^ w_src_b[c_CHUNK-1] ^ w_s[c_CHUNK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_c_msb ^ w_co;
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].r_ctl.valid;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_ctl.carry;
`ifdef PIPELINED_ADDER_OVF_EN
    assign bus.ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule : pipelined_adder

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Scoreboard bench driving WIDTH=8 adders with STAGES 2, 8 and 1
//               from one shared stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder;

    localparam int c_N       = 3;
    localparam int c_ST [c_N] = '{2, 8, 1};

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_ready;

    logic       w_ir  [c_N];
    logic       w_ov  [c_N];
    logic [7:0] w_sum [c_N];
    logic       w_co  [c_N];
    logic       w_ovf [c_N];

    int  n_checks;
    int  n_pass;
    bit  sweep_done;
    logic [9:0] sb [c_N][$];

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        pipelined_adder_if #(.WIDTH(8)) u_if ();

        assign u_if.in_valid  = in_valid;
        assign u_if.a         = a;
        assign u_if.b         = b;
        assign u_if.cin       = cin;
        assign u_if.out_ready = out_ready;
        assign w_ir[g]        = u_if.in_ready;
        assign w_ov[g]        = u_if.out_valid;
        assign w_sum[g]       = u_if.sum;
        assign w_co[g]        = u_if.cout;
`ifdef PIPELINED_ADDER_OVF_EN
        assign w_ovf[g]       = u_if.ovf;
`else
        assign w_ovf[g]       = 1'b0;
`endif

        pipelined_adder #(
            .WIDTH  (8),
            .STAGES (c_ST[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // {ovf, cout, sum}; overflow by the sign rule on the operands.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'd0, c};
`ifdef PIPELINED_ADDER_OVF_EN
        v = (x[7] == y[7]) && (t[7] != x[7]);
`else
        v = 1'b0;
`endif
        return {v, t};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the edge that took the operands.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
        int budget;
        budget   = 100;
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!w_ir[0] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit sb_empty();
        return (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
    endfunction

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        sweep_done = 1'b0;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b1;

        fork
            forever begin
                logic [9:0] e;
                @(negedge clk or negedge rst_n);
                if (!rst_n) begin
                    for (int i = 0; i < c_N; i++) sb[i].delete();
                end else begin
                    for (int i = 0; i < c_N; i++) begin
                        if (w_ov[i] && out_ready) begin
                            if (sb[i].size() == 0) begin
                                check($sformatf("stale_s%0d", c_ST[i]), 32'(w_ov[i]), 32'd0);
                            end else begin
                                e = sb[i].pop_front();
                                check($sformatf("result_s%0d", c_ST[i]),
                                      {22'd0, w_ovf[i], w_co[i], w_sum[i]}, {22'd0, e});
                            end
                        end
                        if (in_valid && w_ir[i]) sb[i].push_back(model(a, b, cin));
                    end
                end
            end
        join_none

        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(w_ov[0]), 32'd0);
        check("rst_sum",       32'(w_sum[0]), 32'd0);
        check("rst_cout",      32'(w_co[0]), 32'd0);
        check("rst_ovf",       32'(w_ovf[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < c_N; i++)
            check($sformatf("rst_in_ready_s%0d", c_ST[i]), 32'(w_ir[i]), 32'd1);
        @(posedge clk);
        #1;

        // Latency: STAGES=2 shows the result on the second cycle, STAGES=1 on the first.
        send(8'h3C, 8'h05, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_s2_cyc1_valid", 32'(w_ov[0]), 32'd0);
        check("lat_s1_cyc1_valid", 32'(w_ov[2]), 32'd1);
        check("lat_s1_cyc1_sum",   32'(w_sum[2]), 32'h41);
        @(negedge clk);
        check("lat_s2_cyc2_valid", 32'(w_ov[0]), 32'd1);
        check("lat_s2_cyc2_sum",   32'(w_sum[0]), 32'h41);
        check("lat_s2_cyc2_cout",  32'(w_co[0]), 32'd0);
        @(posedge clk);
        #1;
        idle(12);

        send(8'hFF, 8'h01, 1'b0);
        idle(12);

        // Back-to-back stream with cin=1.
        send(8'h10, 8'h10, 1'b1);
        send(8'h80, 8'h80, 1'b1);
        send(8'h0F, 8'h01, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_2nd_valid", 32'(w_ov[0]), 32'd1);
        check("stream_2nd_sum",   32'(w_sum[0]), 32'h01);
        check("stream_2nd_cout",  32'(w_co[0]), 32'd1);
        @(negedge clk);
        check("stream_3rd_valid", 32'(w_ov[0]), 32'd1);
        check("stream_3rd_sum",   32'(w_sum[0]), 32'h11);
        check("stream_3rd_cout",  32'(w_co[0]), 32'd0);
        @(posedge clk);
        #1;
        idle(12);

        // Output stall with two results in flight and a third operand waiting.
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0);
        send(8'h33, 8'h44, 1'b1);
        a        = 8'h55;
        b        = 8'h66;
        cin      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(w_ir[0]), 32'd0);
            check("stall_out_valid", 32'(w_ov[0]), 32'd1);
            check("stall_sum_hold",  32'(w_sum[0]), 32'h33);
            check("stall_cout_hold", 32'(w_co[0]), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'h55, 8'h66, 1'b0);
        idle(20);
        for (int i = 0; i < c_N; i++)
            check($sformatf("stall_drain_s%0d", c_ST[i]), 32'(sb[i].size()), 32'd0);

        // Reset in the middle of a stream.
        send(8'h01, 8'h02, 1'b0);
        send(8'h03, 8'h04, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(w_ov[0]), 32'd0);
        check("midrst_sum",       32'(w_sum[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(w_ov[0]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random sweep with random back-pressure.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(8'($urandom), 8'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                in_valid   = 1'b0;
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(20);

        send(8'h7F, 8'h01, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        send(8'h40, 8'h20, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !sb_empty(); i++) @(posedge clk);
        #1;
        for (int i = 0; i < c_N; i++)
            check($sformatf("final_drain_s%0d", c_ST[i]), 32'(sb[i].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipelined_adder

`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder. It is the multi-bit, clocked successor to the team's single-bit gate-level full adder.
- Splits a WIDTH-bit add into STAGES equal chunks, with one chunk per pipeline stage; the carry is registered between stages.
- Uses a valid/ready handshake on both sides, so it can sit between streaming producers and consumers in genetic-circuit simulation datapaths.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be ≥ 1.
- STAGES, 2, pipeline depth; must divide WIDTH exactly. CHUNK = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin are presented.
- in_ready  output  1  the block accepts the operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  the consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear.
  - out_valid=0, sum=0, cout=0.
  - in_ready=1 after reset deasserts.
  - Data registers clear to 0.
- Global advance enable: adv = !out_valid | out_ready. Every stage register loads only when adv=1, otherwise all stages hold.
- Handshake:
  - in_ready = adv.
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Stage 0 on adv:
  - Registers bits [CHUNK-1:0] of a+b+cin, plus the chunk carry.
  - Registers the still-unprocessed upper bits of a and b.
  - valid0 <= in_valid.
- Stage k (1 ≤ k < STAGES) on adv:
  - Adds chunk k of the carried operands plus the registered carry from stage k-1.
  - Forwards the lower sum chunks already computed and the remaining upper operand bits.
  - valid_k <= valid_{k-1}.
- Output mapping:
  - out_valid = valid_{STAGES-1}.
  - sum and cout come from the last stage.
- Latency and throughput:
  - Exactly STAGES cycles from accepted input to out_valid when out_ready is held high.
  - Throughput is one result per cycle.
- Bubbles are not collapsed. An empty stage still advances only with adv, which is acceptable because adv=1 whenever the output is empty.
- Arithmetic:
  - Unsigned, wrap-around.
  - {cout,sum} = a + b + cin exactly, over WIDTH+1 bits.
- Boundary conditions:
  - STAGES=1: purely registered adder, latency 1.
  - CHUNK=1: bit-serial-skewed ripple, one bit per stage.
  - Input transfer while output is stalled: impossible by construction, since in_ready=0.
  - Reset mid-operation: all in-flight results are discarded and no out_valid is produced for them.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- When defined:
  - Adds port ovf, output, 1 bit: two's-complement signed overflow, computed as carry into the MSB XOR carry out of the MSB.
  - ovf is registered alongside sum, resets to 0, and is valid with out_valid.
- When undefined: no ovf port and no extra logic. Sum and cout behaviour are identical in both builds.

Decomposition:
- Package pipelined_adder_pkg:
  - Function for CHUNK = WIDTH/STAGES.
  - Elaboration check that WIDTH % STAGES == 0 and STAGES ≥ 1.
  - Stage-record typedef {valid, carry, partial sum, remaining a, remaining b}.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder (a, b, ci → s, co), instantiated once per stage. This is the natural generalisation of the single-bit full adder.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- a=0x3C, b=0x05, cin=0, out_ready=1 → cycle 2: out_valid=1, sum=0x41, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Tests carry crossing the stage boundary (bit 3 → bit 4).
- Back-to-back stream 0x10+0x10, 0x80+0x80, 0x0F+0x01 with cin=1 → results on consecutive cycles: 0x21/0, 0x01/1, 0x11/0.
- out_ready=0 for 3 cycles with 2 results in flight:
  - in_ready=0 and the outputs hold throughout.
  - After release, both results emerge in order with none lost or duplicated.
- rst_n pulsed low mid-stream → out_valid drops asynchronously and no stale result appears afterwards. WIDTH=8, STAGES=8 random sweep → matches the reference model.
- PIPELINED_ADDER_OVF_EN defined:
  - 0x7F+0x01 → ovf=1.
  - 0x80+0x80 → ovf=1, cout=1.
  - 0x40+0x20 → ovf=0.
